// File: rtl/multi_mode_counter.sv
// Loadable up/down counter with programmable step, wrap or saturate at a
// terminal count MAX, a registered bound pulse (tc) and sticky ovf/unf flags.
module multi_mode_counter #(
    parameter int WIDTH  = 8,
    parameter int MAX    = 2**WIDTH - 1,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              ld,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              at_max,
    output logic              at_zero
);

    if (MAX < 1 || MAX > 2**WIDTH - 1) begin : g_bad_max
        $error("multi_mode_counter: MAX must lie in 1..2**WIDTH-1");
    end
    if (2**STEP_W - 1 > MAX) begin : g_bad_step
        $error("multi_mode_counter: largest step exceeds MAX");
    end

    // One extra bit so the up sum and the wrapped down value never truncate
    // before they are compared against the bound.
    localparam logic [WIDTH:0] MAX_X = (WIDTH + 1)'(MAX);
    localparam logic [WIDTH:0] MOD_X = (WIDTH + 1)'(MAX + 1);

    logic [WIDTH:0] q_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] up_wrap;
    logic [WIDTH:0] down_diff;
    logic [WIDTH:0] down_wrap;
    logic           load_over;

    assign q_x       = {1'b0, q};
    assign step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign up_sum    = q_x + step_x;
    assign up_wrap   = up_sum - MOD_X;
    assign down_diff = q_x - step_x;
    assign down_wrap = q_x + MOD_X - step_x;
    assign load_over = {1'b0, data_in} > MAX_X;

    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             ovf_set;
    logic             unf_set;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the branches below can leave a latch behind.
        q_next  = q;
        tc_next = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (ld) begin
            if (load_over) begin
                q_next  = MAX_X[WIDTH-1:0];
                ovf_set = 1'b1;
            end else begin
                q_next = data_in;
            end
        end else if ((inc ^ dec) && (step != '0)) begin
            if (inc) begin
                if (up_sum <= MAX_X) begin
                    q_next  = up_sum[WIDTH-1:0];
                    tc_next = (up_sum == MAX_X);
                end else begin
                    q_next  = sat_mode ? MAX_X[WIDTH-1:0] : up_wrap[WIDTH-1:0];
                    ovf_set = 1'b1;
                    tc_next = 1'b1;
                end
            end else begin
                if (step_x <= q_x) begin
                    q_next  = down_diff[WIDTH-1:0];
                    tc_next = (down_diff == '0);
                end else begin
                    q_next  = sat_mode ? '0 : down_wrap[WIDTH-1:0];
                    unf_set = 1'b1;
                    tc_next = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            q   <= q_next;
            tc  <= tc_next;
            // A flag being set this cycle beats a simultaneous clear.
            ovf <= ovf_set | (ovf & ~clr_flags);
            unf <= unf_set | (unf & ~clr_flags);
        end
    end

    assign at_max  = ({1'b0, q} == MAX_X);
    assign at_zero = (q == '0);

endmodule
